// File: rtl/arbiter_rr_reg_if.sv
// Valid/ready bundle between N producers, the round-robin arbiter and one consumer.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface arbiter_rr_reg_if #(
  parameter int N_INPUTS = 4,
  parameter int DWIDTH   = 8,
  parameter int IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
);

  // Producer side
  logic [N_INPUTS-1:0]        in_valid;
  logic [N_INPUTS*DWIDTH-1:0] in_data;
  logic [N_INPUTS-1:0]        in_ready;

  // Consumer side
  logic                       out_valid;
  logic [DWIDTH-1:0]          out_data;
  logic [IDX_W-1:0]           out_src;
  logic                       out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_src,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_src,
    output out_ready
  );

endinterface

// File: rtl/arbiter_rr_reg.sv
// N-input round-robin arbiter with a single registered output stage.
// The grant scan starts at ptr_q and wraps; after each transfer the pointer moves
// just past the winner so every active requester is eventually served.
// The output register cuts the out_ready -> in_ready path only partially: in_ready
// still depends on out_ready through can_load, which is what allows 1 token/cycle.
module arbiter_rr_reg #(
  parameter int N_INPUTS = 4,
  parameter int DWIDTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  arbiter_rr_reg_if.slave   bus
);

  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  // (base + offs) mod N_INPUTS, with base < N_INPUTS and offs < N_INPUTS,
  // so a single conditional subtract is enough even for non-power-of-2 N_INPUTS.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int offs);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, base} + SUM_W'(offs);
    if (sum >= SUM_W'(N_INPUTS)) begin
      sum = sum - SUM_W'(N_INPUTS);
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // Index following the winner; wraps to 0 after the last requester.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx == LAST_IDX) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

  // Architectural state
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    ptr_d;
  logic                out_valid_q;
  logic                out_valid_d;
  logic [DWIDTH-1:0]   out_data_q;
  logic [DWIDTH-1:0]   out_data_d;
  logic [IDX_W-1:0]    out_src_q;
  logic [IDX_W-1:0]    out_src_d;

  // Arbitration intermediates
  logic                can_load_s;
  logic                grant_vld_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic [IDX_W-1:0]    cand_s;
  logic [N_INPUTS-1:0] grant_s;
  logic [DWIDTH-1:0]   grant_data_s;
  logic                xfer_s;

  // The register can take a new token when it is empty or being drained now.
  assign can_load_s = ~out_valid_q | bus.out_ready;

  // Rotating priority scan: walk offsets from the far end back to 0 so the
  // valid requester closest to ptr_q (offset 0 first) is the one left standing.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      cand_s = wrap_add(ptr_q, k);
      if (bus.in_valid[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    grant_s = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant_vld_s && (grant_idx_s == IDX_W'(i))) begin
        grant_s[i] = 1'b1;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  // Select the winner's payload with an AND-OR mux over the one-hot grant.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant_s[i]) begin
        grant_data_s = grant_data_s | bus.in_data[i*DWIDTH +: DWIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // in_ready is gated by rst_n directly so no handshake can complete during reset.
  assign bus.in_ready = {N_INPUTS{rst_n & can_load_s}} & grant_s;

  // A grant only turns into a transfer when the output register can load.
  assign xfer_s = grant_vld_s & can_load_s;

  // Next state of the output register and the priority pointer.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data_s;
      out_src_d   = grant_idx_s;
      ptr_d       = next_ptr(grant_idx_s);
    end else if (out_valid_q && bus.out_ready) begin
      // Drained with nothing to replace it: data/src keep their last value.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset; a held token is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule
